decryption_regfile_master: RTL and testbench



---
 rtl/decryption_regfile_master.sv | 126 ++++++++++++
 tb/tb_decryption_regfile_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/decryption_regfile_master.sv
// Bus initiator for the decryption key/select register file.
// Takes one read or write command at a time, pulses a single-cycle strobe on the
// register file bus, waits for `done` (guarded by a watchdog) and hands the
// result back on a valid/ready response port.
module decryption_regfile_master #(
    parameter int unsigned addr_width     = 8,
    parameter int unsigned reg_width      = 16,
    parameter int unsigned timeout_cycles = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [reg_width-1:0]  cmd_wdata,

    // Response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [reg_width-1:0]  rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,

    // Register file bus
    output logic [addr_width-1:0] addr,
    output logic                  read,
    output logic                  write,
    output logic [reg_width-1:0]  wdata,
    input  logic [reg_width-1:0]  rdata,
    input  logic                  done,
    input  logic                  error
);

    // Wide enough to count up to timeout_cycles without wrapping.
    localparam int unsigned cnt_width = $clog2(timeout_cycles + 1);
    localparam logic [cnt_width-1:0] cnt_last = cnt_width'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e               state;
    logic [cnt_width-1:0] wait_cnt;
    // Remembers the operation type after the strobe has been dropped.
    logic                 op_read;

    // The only unregistered output: ready is a pure state decode.
    assign cmd_ready = (state == StIdle);

    // Transaction sequencer; every bus and response output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            wait_cnt    <= '0;
            op_read     <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        // addr/wdata stay put until the next accept: the
                        // register file decodes its error from addr every cycle.
                        addr     <= cmd_addr;
                        wdata    <= cmd_wdata;
                        write    <= cmd_write;
                        read     <= !cmd_write;
                        op_read  <= !cmd_write;
                        wait_cnt <= '0;
                        state    <= StIssue;
                    end
                end

                StIssue: begin
                    // Strobe is high for exactly this one cycle.
                    read  <= 1'b0;
                    write <= 1'b0;
                    state <= StWait;
                end

                StWait: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (done) begin
                        // Completion wins over a coincident timeout.
                        rsp_rdata   <= op_read ? rdata : '0;
                        rsp_error   <= error;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= StResp;
                    end else if (wait_cnt == cnt_last) begin
                        rsp_rdata   <= '0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= StResp;
                    end
                end

                StResp: begin
                    // rsp_* hold until consumed.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decryption_regfile_master.sv
// Self-checking bench for decryption_regfile_master with a small register file
// model on the bus and a scoreboard of expected responses.
module tb_decryption_regfile_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [7:0]  addr;
    logic        read;
    logic        write;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done;
    logic        error;

    decryption_regfile_master #(
        .addr_width     (8),
        .reg_width      (16),
        .timeout_cycles (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .addr        (addr),
        .read        (read),
        .write       (write),
        .wdata       (wdata),
        .rdata       (rdata),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: 0x10 read/write, 0x12 reads 0xFFFF, anything else errors.
    logic [15:0] reg10;
    logic        mute;   // suppress done to provoke a timeout
    logic        inj;    // force a done pulse on the next edge
    always @(posedge clk) begin
        done <= ((read || write) && !mute) || inj;
        if (write && addr == 8'h10) reg10 <= wdata;
    end
    assign error = done && !(addr == 8'h10 || addr == 8'h12);
    // Returns the register value even on writes so write-data masking is visible.
    assign rdata = !done ? 16'h0 : (addr == 8'h10) ? reg10 : (addr == 8'h12) ? 16'hFFFF : 16'h0;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        logic        to;
    } exp_t;
    exp_t sb[$];

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_strobes"}, {30'd0, read, write}, 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_wdata"}, 32'(wdata), 32'd0);
        check({tag, "_rsp"}, {14'd0, rsp_rdata, rsp_error, rsp_timeout}, 32'd0);
    endtask

    // One full transaction: accept, strobe/latency checks, scoreboard compare,
    // optional response backpressure, handshake.
    task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [15:0] d,
                           input logic [15:0] er, input logic ee, input logic et,
                           input int hold, input int exp_lat, input int inj_cycle);
        exp_t e;
        exp_t cur;
        int   lat;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clk);
        e.rdata = er;
        e.err   = ee;
        e.to    = et;
        sb.push_back(e);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("strobe_c1", {30'd0, read, write}, {30'd0, !wr, wr});
                check("addr_c1", 32'(addr), 32'(a));
                check("wdata_c1", 32'(wdata), 32'(d));
            end else begin
                check("strobe_off", {30'd0, read, write}, 32'd0);
            end
            inj = (inj_cycle > 0) && (lat == inj_cycle - 1);
        end while (!rsp_valid && lat < 40);
        inj = 1'b0;
        if (!rsp_valid) begin
            check("rsp_valid_bound", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        cur = sb.pop_front();
        check("rsp", {14'd0, rsp_rdata, rsp_error, rsp_timeout},
              {14'd0, cur.rdata, cur.err, cur.to});
        // Backpressure: a competing command must be ignored while rsp is pending.
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 8'h99;
            @(negedge clk);
            check("hold_rsp", {13'd0, rsp_valid, rsp_rdata, rsp_error, rsp_timeout},
                  {13'd0, 1'b1, cur.rdata, cur.err, cur.to});
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_addr", 32'(addr), 32'(a));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("cmd_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        bit seen_v;
        bit seen_s;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        mute      = 1'b0;
        inj       = 1'b0;
        reg10     = 16'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // wr, addr, wdata, exp_rdata, exp_err, exp_to, hold, latency, inject
        run_cmd(1'b1, 8'h10, 16'h0003, 16'h0000, 1'b0, 1'b0, 0, 3, 0);
        run_cmd(1'b0, 8'h12, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0, 3, 0);
        run_cmd(1'b0, 8'h10, 16'h0000, 16'h0003, 1'b0, 1'b0, 0, 3, 0);
        run_cmd(1'b0, 8'h11, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 3, 0);
        run_cmd(1'b0, 8'h12, 16'hABCD, 16'hFFFF, 1'b0, 1'b0, 5, 3, 0);
        run_cmd(1'b1, 8'h10, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 2, 3, 0);
        run_cmd(1'b0, 8'h10, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 0, 3, 0);

        // Watchdog: no done at all, then done arriving in the last WAIT cycle.
        mute = 1'b1;
        run_cmd(1'b0, 8'h10, 16'h0000, 16'h0000, 1'b1, 1'b1, 0, 17, 0);
        run_cmd(1'b0, 8'h12, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0, 17, 16);

        // Reset while waiting for done.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h55;
        cmd_wdata = 16'h1234;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_wait_reset");
        rst_n = 1'b1;
        seen_v = 1'b0;
        seen_s = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen_v = 1'b1;
            if (read || write) seen_s = 1'b1;
        end
        check("post_reset_no_rsp", 32'(seen_v), 32'd0);
        check("post_reset_no_strobe", 32'(seen_s), 32'd0);
        check("post_reset_ready", 32'(cmd_ready), 32'd1);
        mute = 1'b0;

        run_cmd(1'b0, 8'h10, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 0, 3, 0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
